// File: rtl/i2s_serializer.sv
// Parallel-to-I2S output stage: double-buffers one L/R sample pair and emits a free-running Philips I2S stream.
// Build option: define I2S_MUTE_ON_UNDERRUN_EN to send silence on underrun instead of repeating the last pair.
module i2s_serializer #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic signed [WIDTH-1:0] i_data_l,
    input  logic signed [WIDTH-1:0] i_data_r,
    input  logic                    i_valid,
    output logic                    o_bclk,
    output logic                    o_lrck,
    output logic                    o_sdata,
    output logic                    o_underrun,
    output logic                    o_overrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT     = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(WIDTH);

    logic [DIV_W-1:0]        div_cnt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_nxt;
    logic [CNT_W-1:0]        k_nxt;
    logic                    fall;
    logic                    frame_load;
    logic                    slot_r_nxt;
    logic                    data_bit;
    logic                    pend_v;
    logic                    underrun_nxt;
    logic signed [WIDTH-1:0] pend_l, pend_r;
    logic signed [WIDTH-1:0] sh_l, sh_r;
    logic signed [WIDTH-1:0] last_l, last_r;
    logic signed [WIDTH-1:0] src_l, src_r;

    // Every data-side event happens on the i_clk cycle in which BCLK is registered falling.
    assign fall       = (div_cnt == DIV_LAST) && o_bclk;
    assign bit_nxt    = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    assign frame_load = fall && (bit_cnt == CNT_LAST);
    assign slot_r_nxt = (bit_nxt >= SLOT);
    assign k_nxt      = slot_r_nxt ? bit_nxt - SLOT : bit_nxt;
    assign data_bit   = (k_nxt != '0) && (k_nxt <= K_LAST);

    // A strobe landing on the load cycle bypasses the pending buffer so it is sent this frame.
    always_comb begin
        src_l        = pend_l;
        src_r        = pend_r;
        underrun_nxt = 1'b0;
        if (i_valid) begin
            src_l = i_data_l;
            src_r = i_data_r;
        end else if (!pend_v) begin
            underrun_nxt = 1'b1;
`ifdef I2S_MUTE_ON_UNDERRUN_EN
            src_l = '0;
            src_r = '0;
`else
            src_l = last_l;
            src_r = last_r;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt    <= '0;
            o_bclk     <= 1'b0;
            bit_cnt    <= CNT_LAST;
            o_lrck     <= 1'b1;
            o_sdata    <= 1'b0;
            o_underrun <= 1'b0;
            o_overrun  <= 1'b0;
            pend_v     <= 1'b0;
            last_l     <= '0;
            last_r     <= '0;
        end else begin
            o_underrun <= frame_load && underrun_nxt;
            o_overrun  <= i_valid && pend_v && !frame_load;

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                o_bclk  <= !o_bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall) begin
                bit_cnt <= bit_nxt;
                o_lrck  <= slot_r_nxt;
                o_sdata <= data_bit ? (slot_r_nxt ? sh_r[WIDTH-1] : sh_l[WIDTH-1]) : 1'b0;
            end

            if (frame_load) begin
                pend_v <= 1'b0;
                last_l <= src_l;
                last_r <= src_r;
            end else if (i_valid) begin
                pend_v <= 1'b1;
            end
        end
    end

    // Sample storage needs no reset: pend_v and the frame load gate every read of it.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            pend_l <= i_data_l;
            pend_r <= i_data_r;
        end
        if (frame_load) begin
            sh_l <= src_l;
            sh_r <= src_r;
        end else if (fall && data_bit) begin
            if (slot_r_nxt) begin
                sh_r <= sh_r << 1;
            end else begin
                sh_l <= sh_l << 1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer at default parameters (one frame = 256 clocks, BCLK period = 4 clocks).
module tb_i2s_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dl = '0;
    logic [15:0] dr = '0;
    logic        vld = 1'b0;
    logic        bclk, lrck, sdata, und, ovr;
    int          total = 0;
    int          bad = 0;

    localparam logic [63:0] DATA_MASK = 64'h7FFF8000_7FFF8000;

    i2s_serializer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_l(dl), .i_data_r(dr), .i_valid(vld),
        .o_bclk(bclk), .o_lrck(lrck), .o_sdata(sdata), .o_underrun(und), .o_overrun(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vld   = 1'b0;
        rst_n = 1'b0;
        step();
        chk("rst_bclk", 64'(bclk), 64'd0);
        chk("rst_lrck", 64'(lrck), 64'd1);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_und", 64'(und), 64'd0);
        chk("rst_ovr", 64'(ovr), 64'd0);
        step();
        rst_n = 1'b1;
    endtask

    // Walks the four clocks after reset release, optionally strobing a pair at cycle 1.
    task automatic check_start(input string tag, input bit strobe, input logic [15:0] l,
                               input logic [15:0] r, input logic exp_und);
        if (strobe) begin
            vld = 1'b1; dl = l; dr = r;
        end
        step();
        vld = 1'b0;
        chk({tag, "_c1_bclk"}, 64'(bclk), 64'd0);
        step();
        chk({tag, "_c2_bclk"}, 64'(bclk), 64'd1);
        chk({tag, "_c2_lrck"}, 64'(lrck), 64'd1);
        step();
        step();
        chk({tag, "_c4_bclk"}, 64'(bclk), 64'd0);
        chk({tag, "_c4_lrck"}, 64'(lrck), 64'd0);
        chk({tag, "_c4_und"}, 64'(und), 64'(exp_und));
    endtask

    // Starts on a frame-load cycle, records one frame bit per BCLK rise, ends on the next load cycle.
    task automatic run_frame(input int s1, input logic [15:0] l1, input logic [15:0] r1,
                             input int s2, input logic [15:0] l2, input logic [15:0] r2,
                             output logic [63:0] fr, output int nund, output int novr,
                             output int nedge);
        logic ps, pl;
        fr = '0; nund = 0; novr = 0; nedge = 0;
        ps = sdata; pl = lrck;
        for (int j = 0; j < 256; j++) begin
            nund += int'(und);
            novr += int'(ovr);
            if (j % 4 == 2) begin
                fr[63 - j / 4] = sdata;
                if (bclk !== 1'b1) nedge++;
                if (lrck !== ((j / 4) >= 32)) nedge++;
            end
            if ((j % 4 != 0) && (sdata !== ps || lrck !== pl)) nedge++;
            ps = sdata; pl = lrck;
            if (j == s1) begin
                vld = 1'b1; dl = l1; dr = r1;
            end else if (j == s2) begin
                vld = 1'b1; dl = l2; dr = r2;
            end else begin
                vld = 1'b0;
            end
            step();
        end
        vld = 1'b0;
    endtask

    task automatic frame_chk(input string tag, input logic [63:0] fr, input int nund, input int novr,
                             input int nedge, input logic [15:0] el, input logic [15:0] er,
                             input int eund, input int eovr);
        chk({tag, "_left"}, 64'(fr[62:47]), 64'(el));
        chk({tag, "_right"}, 64'(fr[30:15]), 64'(er));
        chk({tag, "_idle_bits"}, fr & ~DATA_MASK, 64'd0);
        chk({tag, "_und"}, 64'(nund), 64'(eund));
        chk({tag, "_ovr"}, 64'(novr), 64'(eovr));
        chk({tag, "_edges"}, 64'(nedge), 64'd0);
    endtask

    initial begin
        logic [63:0] fr;
        int nu, no, ne;
        logic [15:0] h_a5l, h_a5r, h_7fl, h_7fr, h_ff;
`ifdef I2S_MUTE_ON_UNDERRUN_EN
        h_a5l = 16'h0000; h_a5r = 16'h0000; h_7fl = 16'h0000; h_7fr = 16'h0000; h_ff = 16'h0000;
`else
        h_a5l = 16'hA5C3; h_a5r = 16'h1234; h_7fl = 16'h7FFF; h_7fr = 16'h8000; h_ff = 16'h00FF;
`endif

        // Idle after reset: silence with one underrun per frame.
        do_reset();
        check_start("s1", 1'b0, 16'h0, 16'h0, 1'b1);
        run_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s1_f0", fr, nu, no, ne, 16'h0000, 16'h0000, 1, 0);
        run_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s1_f1", fr, nu, no, ne, 16'h0000, 16'h0000, 1, 0);

        // Sample strobed before the first load goes out in the first frame.
        do_reset();
        check_start("s2", 1'b1, 16'hA5C3, 16'h1234, 1'b0);
        run_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s2", fr, nu, no, ne, 16'hA5C3, 16'h1234, 0, 0);

        // Two strobes in one frame: the second overwrites and raises overrun.
        run_frame(10, 16'h1111, 16'h1111, 100, 16'h2222, 16'h2222, fr, nu, no, ne);
        frame_chk("s3_hold", fr, nu, no, ne, h_a5l, h_a5r, 1, 1);
        // Strobe on the last cycle of the frame lands exactly on the load edge.
        run_frame(255, 16'h7FFF, 16'h8000, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s3_new", fr, nu, no, ne, 16'h2222, 16'h2222, 0, 0);
        run_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s4_bypass", fr, nu, no, ne, 16'h7FFF, 16'h8000, 0, 0);
        run_frame(50, 16'h00FF, 16'h00FF, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s4_after", fr, nu, no, ne, h_7fl, h_7fr, 1, 0);

        // Load then starve.
        run_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s5_load", fr, nu, no, ne, 16'h00FF, 16'h00FF, 0, 0);
        run_frame(10, 16'h5555, 16'h0F0F, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s5_starve", fr, nu, no, ne, h_ff, h_ff, 1, 0);

        // Mid-frame reset at bit_cnt 40 (right slot k=8, bit 8 of 0x0F0F is 1) with a sample pending.
        for (int j = 0; j < 163; j++) begin
            if (j == 20) begin
                vld = 1'b1; dl = 16'h3333; dr = 16'h3333;
            end else begin
                vld = 1'b0;
            end
            step();
        end
        vld = 1'b0;
        chk("s6_pre_bclk", 64'(bclk), 64'd1);
        chk("s6_pre_lrck", 64'(lrck), 64'd1);
        chk("s6_pre_sdata", 64'(sdata), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_bclk", 64'(bclk), 64'd0);
        chk("s6_async_lrck", 64'(lrck), 64'd1);
        chk("s6_async_sdata", 64'(sdata), 64'd0);
        chk("s6_async_und", 64'(und), 64'd0);
        chk("s6_async_ovr", 64'(ovr), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        check_start("s6", 1'b0, 16'h0, 16'h0, 1'b1);
        run_frame(-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, fr, nu, no, ne);
        frame_chk("s6_restart", fr, nu, no, ne, 16'h0000, 16'h0000, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
